// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;

   localparam int REG_ADDR_W       = 5;
   localparam int XLEN             = 64;
   localparam int LQ_DEPTH_DEFAULT = 4;

   // One register-file write request: destination and value.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Round-robin pointer: which source wins the next contended cycle.
   typedef enum logic {
      RR_FAVOR_A = 1'b0,
      RR_FAVOR_L = 1'b1
   } rr_ptr_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Circular load-response queue. Head entry is visible combinationally so
// the arbiter can grant it in the same cycle it becomes the oldest entry.
// A push into a full queue is accepted only if a pop happens that cycle;
// otherwise the entry is dropped and the sticky overflow flag is set.
module wb_load_fifo
   import regfile_pkg::*;
#(
   parameter  int DEPTH = LQ_DEPTH_DEFAULT,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_req_t          push_req,
   input  logic             pop,
   output wb_req_t          head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam logic [PTR_W-1:0] PTR_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_DEPTH = DEPTH;

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_reg == CNT_DEPTH);
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign overflow = overflow_reg;
   assign head     = mem[rd_ptr_reg];

   // When full, wr_ptr equals rd_ptr; the simultaneous pop has already read
   // the head combinationally, so overwriting that slot is safe.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_req;
      end
   end

   // Pointers, occupancy and sticky overflow; pointers wrap at DEPTH (power of two).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         if (push && !push_ok) begin
            overflow_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (valid/ready) and the
// load unit (valid-only, buffered in wb_load_fifo). The winner is staged for
// one cycle and presented as RegWrite/RD/WriteData for the negedge commit.
// Writes to x0 are granted but suppressed.
// Optional macro WB_FWD_EN adds two forwarding lookups against the staging
// register for the half cycle before the register file commits it.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int LQ_DEPTH  = LQ_DEPTH_DEFAULT,
   parameter int LOAD_PRIO = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     a_valid,
   input  logic [4:0]               a_rd,
   input  logic [63:0]              a_data,
   output logic                     a_ready,
   input  logic                     l_valid,
   input  logic [4:0]               l_rd,
   input  logic [63:0]              l_data,
   output logic                     RegWrite,
   output logic [4:0]               RD,
   output logic [63:0]              WriteData,
   output logic [$clog2(LQ_DEPTH):0] lq_count,
   output logic                     lq_full,
   output logic                     lq_overflow
`ifdef WB_FWD_EN
   ,
   input  logic [4:0]               fq_rs1,
   input  logic [4:0]               fq_rs2,
   output logic                     fq_hit1,
   output logic                     fq_hit2,
   output logic [63:0]              fq_data1,
   output logic [63:0]              fq_data2
`endif
);

   wb_req_t          l_push_req;
   wb_req_t          a_req;
   wb_req_t          lq_head;
   wb_req_t          win_req;
   logic             lq_empty;
   logic             contended;
   logic             grant_a;
   logic             grant_l;
   rr_ptr_t          rr_ptr_reg;
   logic             regwrite_reg;
   logic [4:0]       rd_reg;
   logic [63:0]      wdata_reg;

   assign l_push_req = {l_rd, l_data};
   assign a_req      = {a_rd, a_data};

   // Loads always enqueue; a load is never granted in its arrival cycle.
   wb_load_fifo #(
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk      (clk),
      .reset    (reset),
      .push     (l_valid),
      .push_req (l_push_req),
      .pop      (grant_l),
      .head     (lq_head),
      .count    (lq_count),
      .full     (lq_full),
      .empty    (lq_empty),
      .overflow (lq_overflow)
   );

   // Pick one source per cycle: fixed load priority or round-robin.
   always_comb begin
      grant_a   = 1'b0;
      grant_l   = 1'b0;
      contended = a_valid && !lq_empty;
      if (contended) begin
         if (LOAD_PRIO != 0 || rr_ptr_reg == RR_FAVOR_L) begin
            grant_l = 1'b1;
         end else begin
            grant_a = 1'b1;
         end
      end else begin
         grant_a = a_valid;
         grant_l = !lq_empty;
      end
   end

   assign a_ready = grant_a;
   assign win_req = grant_l ? lq_head : a_req;

   // Round-robin pointer flips to the loser only after a contended grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_reg <= RR_FAVOR_A;
      end else if (contended) begin
         rr_ptr_reg <= grant_a ? RR_FAVOR_L : RR_FAVOR_A;
      end
   end

   // Staging register; x0 grants and idle cycles leave RD/WriteData untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_reg <= 1'b0;
         rd_reg       <= '0;
         wdata_reg    <= '0;
      end else if ((grant_a || grant_l) && win_req.rd != '0) begin
         regwrite_reg <= 1'b1;
         rd_reg       <= win_req.rd;
         wdata_reg    <= win_req.data;
      end else begin
         regwrite_reg <= 1'b0;
      end
   end

   assign RegWrite  = regwrite_reg;
   assign RD        = rd_reg;
   assign WriteData = wdata_reg;

`ifdef WB_FWD_EN
   logic [4:0]  fq_rs   [2];
   logic        fq_hit  [2];
   logic [63:0] fq_data [2];

   assign fq_rs[0] = fq_rs1;
   assign fq_rs[1] = fq_rs2;

   // Each lookup hits only a live, non-x0 write in the staging register.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fq_hit[gi]  = regwrite_reg && (rd_reg == fq_rs[gi]) && (fq_rs[gi] != '0);
      assign fq_data[gi] = fq_hit[gi] ? wdata_reg : '0;
   end

   assign fq_hit1  = fq_hit[0];
   assign fq_hit2  = fq_hit[1];
   assign fq_data1 = fq_data[0];
   assign fq_data2 = fq_data[1];
`endif

endmodule
